lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store controller. Drives the data-memory bus through a valid/ready request channel and a valid-only response channel.
- Formats load data into mem2reg_data for the writeback pipeline register.
- Generates pipe_en, which stalls the pipeline while a bus transaction is outstanding.
- It is the producer side of the writeback register: it supplies that register's data input and its pipe_en.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ+WAIT_RSP before the transaction is abandoned with bus_err.
- CNT_W, 5: timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req  in  1  MEM stage holds a load/store this cycle
- is_load  in  1  operation is a load (else store)
- funct3  in  3  RISC-V width/sign code
- addr  in  32  effective byte address
- wdata  in  32  store data (rs2)
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  memory accepts request
- bus_we  out  1  1=write
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_wmask  out  4  byte-lane enables
- bus_rsp_valid  in  1  read data valid
- bus_rdata  in  32  read word
- mem2reg_data  out  32  formatted load result
- pipe_en  out  1  1=pipeline may advance
- fault  out  1  one-cycle pulse: misaligned or illegal funct3
- bus_err  out  1  one-cycle pulse: timeout

Behaviour:
- Reset (rst=0, async): state=IDLE; all registered outputs 0, including mem2reg_data, fault, bus_err, bus_req_valid and the latched request fields; timeout counter cleared.
- Combinational pipe_en: 1 in IDLE unless a legal request is being accepted; 0 in REQ and WAIT_RSP; 1 in DONE.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000, 001, 010
- Misaligned conditions: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE:
  - mem_req with legal, aligned op: latch addr, funct3, is_load, wdata → REQ.
  - Illegal or misaligned op: no bus activity, fault=1 the next cycle, pipe_en stays 1, remain in IDLE.
- REQ:
  - bus_req_valid=1; bus_we, bus_addr, bus_wdata and bus_wmask are stable from registers until the handshake.
  - Handshake (valid & ready): a store goes to DONE; a load goes to WAIT_RSP.
- WAIT_RSP: on bus_rsp_valid, capture the formatted load data into mem2reg_data → DONE. A bus_rsp_valid seen in any other state is ignored.
- DONE: pipe_en=1 for exactly one cycle → IDLE. A new mem_req sampled in DONE is not accepted; it is accepted in the following IDLE cycle.
- Timeout:
  - The counter clears on entry to REQ and increments every REQ/WAIT_RSP cycle.
  - When it reaches TIMEOUT_CYCLES: → DONE, bus_err=1 for one cycle, bus_req_valid drops, mem2reg_data=0 for a load (a store leaves it unchanged).
  - If the handshake or response arrives in the same cycle the count is reached, the handshake/response wins and there is no error.
- Store lanes:
  - SB: mask 4'b0001<<addr[1:0], wdata[7:0] replicated ×4.
  - SH: mask 4'b0011<<{addr[1],1'b0}, wdata[15:0] replicated ×2.
  - SW: mask 4'hF, wdata unchanged.
- Load formatting:
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- mem2reg_data holds its value between loads; stores do not modify it.
- Reset asserted mid-transaction: immediate return to IDLE with outputs cleared. An in-flight response arriving after reset is ignored.
- Minimum latency:
  - Store: 3 cycles accept→IDLE, with ready=1 in REQ.
  - Load: 4 cycles, with the response 1 cycle after the handshake.

Decomposition:
- Shared package lsu_pkg:
  - state enum (IDLE, REQ, WAIT_RSP, DONE)
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU
  - function functions for store-mask and lane replication
- One sub-module: lsu_load_align, a combinational (rdata, addr[1:0], funct3) → formatted 32-bit word; it is reused by the forwarding logic.
- FSM, counter and the store-lane logic stay in lsu_mem_ctrl.

Test Plan:
- LW, addr=0x100, ready=1, rsp 1 cycle later with rdata=0xDEADBEEF → bus_addr=0x100, bus_we=0, mem2reg_data=0xDEADBEEF in DONE, pipe_en low for 3 cycles.
- LB addr=0x103, rdata=0x80000000 → 0xFFFFFF80. LBU same → 0x00000080. LH addr=0x102, rdata=0x8001_0000 → 0xFFFF8001.
- SH addr=0x206, wdata=0x1234ABCD, ready delayed 3 cycles → bus_wmask=4'b1100, bus_wdata=0xABCDABCD, fields stable while waiting, pipe_en=0 until DONE.
- LW addr=0x101 → fault pulses once, bus_req_valid never asserts, pipe_en stays 1. funct3=011 load → same response.
- Load with no response → bus_err pulses TIMEOUT_CYCLES cycles after accept, mem2reg_data=0, then IDLE. Response on the exact timeout cycle → no bus_err.
- rst=0 asserted while in WAIT_RSP → IDLE with all outputs 0 immediately. A late bus_rsp_valid is ignored. The next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic op_legal(input logic ld, input logic [2:0] f3);
    if (ld) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // f3[1:0] encodes access size for both signed and unsigned loads
  function automatic logic op_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return !a[0];
      2'b10:   return a == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    return 4'b0001 << a;
      F3_H:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends the addressed byte/halfword from a read word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_W:    data = rdata;
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller: bus request/response FSM, store lane
// formatting, load result register and pipeline stall generation.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem2reg_data,
  output logic        pipe_en,
  output logic        fault,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             ld_q;
  logic [2:0]       f3_q;
  logic [1:0]       a_lo_q;
  logic [31:0]      load_data;
  logic             op_ok, accept, busy, hs, rsp, timeout;

  assign op_ok   = op_legal(is_load, funct3) && op_aligned(funct3, addr[1:0]);
  assign accept  = (state == IDLE) && mem_req && op_ok;
  assign busy    = (state == REQ) || (state == WAIT_RSP);
  assign hs      = (state == REQ) && bus_req_ready;
  assign rsp     = (state == WAIT_RSP) && bus_rsp_valid;
  // a handshake or response landing on the last counted cycle wins
  assign timeout = busy && (cnt == CNT_LAST) && !(hs || rsp);

  lsu_load_align u_align (
    .rdata   (bus_rdata),
    .addr_lo (a_lo_q),
    .funct3  (f3_q),
    .data    (load_data)
  );

  always_comb begin
    state_n = state;
    pipe_en = 1'b1;
    case (state)
      IDLE: if (accept) begin
        state_n = REQ;
        pipe_en = 1'b0;
      end
      REQ: begin
        pipe_en = 1'b0;
        if (hs)           state_n = ld_q ? WAIT_RSP : DONE;
        else if (timeout) state_n = DONE;
      end
      WAIT_RSP: begin
        pipe_en = 1'b0;
        if (rsp || timeout) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      ld_q          <= 1'b0;
      f3_q          <= 3'd0;
      a_lo_q        <= 2'd0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'd0;
      bus_wdata     <= 32'd0;
      bus_wmask     <= 4'd0;
      mem2reg_data  <= 32'd0;
      fault         <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      state   <= state_n;
      fault   <= (state == IDLE) && mem_req && !op_ok;
      bus_err <= timeout;
      if (accept) begin
        cnt           <= '0;
        ld_q          <= is_load;
        f3_q          <= funct3;
        a_lo_q        <= addr[1:0];
        bus_req_valid <= 1'b1;
        bus_we        <= !is_load;
        bus_addr      <= {addr[31:2], 2'b00};
        bus_wdata     <= store_lanes(funct3, wdata);
        bus_wmask     <= is_load ? 4'd0 : store_mask(funct3, addr[1:0]);
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (hs || timeout) bus_req_valid <= 1'b0;
      if (rsp)                  mem2reg_data <= load_data;
      else if (timeout && ld_q) mem2reg_data <= 32'd0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, is_load;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata, mem2reg_data;
  logic        pipe_en, fault, bus_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .is_load       (is_load),
    .funct3        (funct3),
    .addr          (addr),
    .wdata         (wdata),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wmask     (bus_wmask),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .mem2reg_data  (mem2reg_data),
    .pipe_en       (pipe_en),
    .fault         (fault),
    .bus_err       (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus_req_valid), 0);
    chk({tag, "_we"},    32'(bus_we), 0);
    chk({tag, "_addr"},  bus_addr, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_wmask"}, 32'(bus_wmask), 0);
    chk({tag, "_m2r"},   mem2reg_data, 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_err"},   32'(bus_err), 0);
    chk({tag, "_pen"},   32'(pipe_en), 1);
  endtask

  // accept -> REQ (ready) -> WAIT (rsp) -> DONE -> IDLE
  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    int low = 0;
    mem_req = 1; is_load = 1; funct3 = f3; addr = a; bus_req_ready = 1;
    @(negedge clk); if (!pipe_en) low++;
    step; mem_req = 0;
    @(negedge clk); if (!pipe_en) low++;
    chk({tag, "_valid"}, 32'(bus_req_valid), 1);
    chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_we"}, 32'(bus_we), 0);
    step; bus_rsp_valid = 1; bus_rdata = rd;
    @(negedge clk); if (!pipe_en) low++;
    step; bus_rsp_valid = 0;
    @(negedge clk);
    chk({tag, "_pen_done"}, 32'(pipe_en), 1);
    chk({tag, "_data"}, mem2reg_data, exp);
    chk({tag, "_stall"}, low, 3);
    step;
  endtask

  task automatic store_quick(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] m, input logic [31:0] lanes);
    mem_req = 1; is_load = 0; funct3 = f3; addr = a; wdata = wd; bus_req_ready = 1;
    step; mem_req = 0;
    @(negedge clk);
    chk({tag, "_wmask"}, 32'(bus_wmask), 32'(m));
    chk({tag, "_wdata"}, bus_wdata, lanes);
    chk({tag, "_we"}, 32'(bus_we), 1);
    step;
    @(negedge clk); chk({tag, "_pen_done"}, 32'(pipe_en), 1);
    step;
  endtask

  task automatic fault_op(input string tag, input logic ld, input logic [2:0] f3, input logic [31:0] a);
    mem_req = 1; is_load = ld; funct3 = f3; addr = a; bus_req_ready = 1;
    @(negedge clk); chk({tag, "_pen0"}, 32'(pipe_en), 1);
    step; mem_req = 0;
    @(negedge clk);
    chk({tag, "_fault"}, 32'(fault), 1);
    chk({tag, "_valid1"}, 32'(bus_req_valid), 0);
    chk({tag, "_pen1"}, 32'(pipe_en), 1);
    step;
    @(negedge clk);
    chk({tag, "_fault_clr"}, 32'(fault), 0);
    chk({tag, "_valid2"}, 32'(bus_req_valid), 0);
    step;
  endtask

  task automatic tmo_op(input string tag, input bit rsp_last, input logic [31:0] prev);
    mem_req = 1; is_load = 1; funct3 = 3'b010; addr = 32'h300; bus_req_ready = 1;
    step; mem_req = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk); chk({tag, "_err_early"}, 32'(bus_err), 0);
      step;
    end
    if (rsp_last) begin bus_rsp_valid = 1; bus_rdata = 32'h0BADF00D; end
    @(negedge clk);
    chk({tag, "_err_c16"}, 32'(bus_err), 0);
    chk({tag, "_pen_c16"}, 32'(pipe_en), 0);
    chk({tag, "_m2r_hold"}, mem2reg_data, prev);
    step; bus_rsp_valid = 0;
    @(negedge clk);
    chk({tag, "_err"}, 32'(bus_err), rsp_last ? 0 : 1);
    chk({tag, "_m2r"}, mem2reg_data, rsp_last ? 32'h0BADF00D : 32'h0);
    chk({tag, "_valid"}, 32'(bus_req_valid), 0);
    chk({tag, "_pen_done"}, 32'(pipe_en), 1);
    step;
    @(negedge clk);
    chk({tag, "_err_clr"}, 32'(bus_err), 0);
    chk({tag, "_pen_idle"}, 32'(pipe_en), 1);
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem_req = 0; is_load = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
    #12;
    chk_idle_zero("reset");
    @(negedge clk); rst = 1;
    step;

    load_op("lw",  3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    load_op("lb",  3'b000, 32'h103, 32'h80000000, 32'hFFFFFF80);
    load_op("lbu", 3'b100, 32'h103, 32'h80000000, 32'h00000080);
    load_op("lh",  3'b001, 32'h102, 32'h80010000, 32'hFFFF8001);
    load_op("lhu", 3'b101, 32'h100, 32'h80017FFE, 32'h00007FFE);

    // SH with ready held off for three REQ cycles
    mem_req = 1; is_load = 0; funct3 = 3'b001; addr = 32'h206; wdata = 32'h1234ABCD;
    bus_req_ready = 0;
    @(negedge clk); chk("sh_pen_acc", 32'(pipe_en), 0);
    step; mem_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sh_valid", 32'(bus_req_valid), 1);
      chk("sh_wmask", 32'(bus_wmask), 32'hC);
      chk("sh_wdata", bus_wdata, 32'hABCDABCD);
      chk("sh_addr", bus_addr, 32'h204);
      chk("sh_we", 32'(bus_we), 1);
      chk("sh_pen", 32'(pipe_en), 0);
      step;
    end
    bus_req_ready = 1;
    @(negedge clk); chk("sh_valid_hs", 32'(bus_req_valid), 1);
    step; bus_req_ready = 0;
    // DONE: a request presented here must wait for the following IDLE cycle
    mem_req = 1; is_load = 1; funct3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    chk("sh_pen_done", 32'(pipe_en), 1);
    chk("sh_valid_done", 32'(bus_req_valid), 0);
    chk("sh_m2r_kept", mem2reg_data, 32'h00007FFE);
    step; bus_req_ready = 1;
    @(negedge clk);
    chk("done_req_idle_pen", 32'(pipe_en), 0);
    chk("done_req_idle_valid", 32'(bus_req_valid), 0);
    step; mem_req = 0;
    @(negedge clk);
    chk("done_req_valid", 32'(bus_req_valid), 1);
    chk("done_req_addr", bus_addr, 32'h80);
    step; bus_rsp_valid = 1; bus_rdata = 32'h11223344;
    step; bus_rsp_valid = 0;
    @(negedge clk); chk("done_req_data", mem2reg_data, 32'h11223344);
    step;

    store_quick("sb", 3'b000, 32'h201, 32'h000000EF, 4'b0010, 32'hEFEFEFEF);
    store_quick("sw", 3'b010, 32'h208, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D);

    fault_op("lw_mis", 1'b1, 3'b010, 32'h101);
    fault_op("ld_f3",  1'b1, 3'b011, 32'h100);
    fault_op("lh_mis", 1'b1, 3'b001, 32'h103);
    fault_op("st_f3",  1'b0, 3'b100, 32'h100);

    tmo_op("tmo", 1'b0, 32'h11223344);
    tmo_op("tmo_rsp", 1'b1, 32'h0);

    // reset while waiting for a response
    mem_req = 1; is_load = 1; funct3 = 3'b010; addr = 32'h400; bus_req_ready = 1;
    step; mem_req = 0;
    step;
    @(negedge clk); chk("rst_pre_pen", 32'(pipe_en), 0);
    #1 rst = 0;
    #1 chk_idle_zero("rst_mid");
    @(negedge clk); rst = 1;
    step; bus_rsp_valid = 1; bus_rdata = 32'h55555555;
    @(negedge clk);
    chk("late_rsp_pen", 32'(pipe_en), 1);
    chk("late_rsp_valid", 32'(bus_req_valid), 0);
    step; bus_rsp_valid = 0;
    @(negedge clk); chk("late_rsp_m2r", mem2reg_data, 0);
    step;
    load_op("lw_post_rst", 3'b010, 32'h404, 32'h600DCAFE, 32'h600DCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
